// File: rtl/multi_issue_pipe_reg.sv
// Lockstep multi-lane decode->execute pipeline register with optional skid entry.
// Flush kills the requesting lane and every younger lane in all stored entries.
module multi_issue_pipe_reg #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 226,
    parameter int SKID      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LANES-1:0]             in_valid,
    input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
    output logic                         in_ready,
    input  logic [LANES-1:0]             flush,
    output logic [LANES-1:0]             out_valid,
    output logic [LANES*PAYLOAD_W-1:0]   out_payload,
    input  logic                         out_ready,
    output logic [31:0]                  stall_cnt
);

    localparam int BW = LANES * PAYLOAD_W;

    logic [LANES-1:0] main_valid_q, main_valid_d;
    logic [BW-1:0]    main_pay_q, main_pay_d;
    logic [LANES-1:0] skid_valid_q, skid_valid_d;
    logic [BW-1:0]    skid_pay_q, skid_pay_d;
    logic             in_ready_q;
    logic [31:0]      stall_q, stall_d;
    logic [LANES-1:0] kill;
    logic             kill_run;
    logic             main_occ, skid_occ, accept;

    // Forces every lane marked invalid to carry an all-zero payload.
    function automatic logic [BW-1:0] zero_dead(input logic [LANES-1:0] v,
                                                input logic [BW-1:0]    p);
        logic [BW-1:0] r;
        r = p;
        for (int i = 0; i < LANES; i++) begin
            if (!v[i]) r[i*PAYLOAD_W +: PAYLOAD_W] = '0;
        end
        return r;
    endfunction

    always_comb begin
        kill     = '0;
        kill_run = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            kill_run = kill_run | flush[i];
            kill[i]  = kill_run;
        end
    end

    assign main_occ = |main_valid_q;
    assign skid_occ = |skid_valid_q;
    assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~main_occ);
    assign accept   = in_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pay_d   = main_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;

        if (SKID != 0) begin
            if (out_ready || !main_occ) begin
                // Skid is always older than anything on the input, so it drains first.
                if (skid_occ) begin
                    main_valid_d = skid_valid_q;
                    main_pay_d   = skid_pay_q;
                    skid_valid_d = '0;
                    skid_pay_d   = '0;
                end else if (accept) begin
                    main_valid_d = in_valid;
                    main_pay_d   = zero_dead(in_valid, in_payload);
                end else begin
                    main_valid_d = '0;
                    main_pay_d   = '0;
                end
            end else if (accept) begin
                skid_valid_d = in_valid;
                skid_pay_d   = zero_dead(in_valid, in_payload);
            end
        end else begin
            if (accept) begin
                main_valid_d = in_valid;
                main_pay_d   = zero_dead(in_valid, in_payload);
            end else if (out_ready) begin
                main_valid_d = '0;
                main_pay_d   = '0;
            end
        end

        main_valid_d = main_valid_d & ~kill;
        skid_valid_d = skid_valid_d & ~kill;
        main_pay_d   = zero_dead(main_valid_d, main_pay_d);
        skid_pay_d   = zero_dead(skid_valid_d, skid_pay_d);

        // A flush that empties main lets surviving skid lanes advance immediately.
        if (!(|main_valid_d) && (|skid_valid_d)) begin
            main_valid_d = skid_valid_d;
            main_pay_d   = skid_pay_d;
            skid_valid_d = '0;
            skid_pay_d   = '0;
        end

        stall_d = stall_q;
        if (main_occ && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= '0;
            main_pay_q   <= '0;
            skid_valid_q <= '0;
            skid_pay_q   <= '0;
            in_ready_q   <= 1'b1;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pay_q   <= main_pay_d;
            skid_valid_q <= skid_valid_d;
            skid_pay_q   <= skid_pay_d;
            in_ready_q   <= ~(|skid_valid_d);
            stall_q      <= stall_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_payload = main_pay_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_multi_issue_pipe_reg.sv
// Directed bench for multi_issue_pipe_reg (2 lanes, skid enabled) with an
// expected-bundle queue for in-order delivery checks.
module tb_multi_issue_pipe_reg;

    localparam int LANES = 2;
    localparam int PW    = 226;
    localparam int BW    = LANES * PW;

    typedef struct {
        logic [LANES-1:0] v;
        logic [BW-1:0]    p;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [LANES-1:0] in_valid;
    logic [BW-1:0]    in_payload;
    logic             in_ready;
    logic [LANES-1:0] flush;
    logic [LANES-1:0] out_valid;
    logic [BW-1:0]    out_payload;
    logic             out_ready;
    logic [31:0]      stall_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    multi_issue_pipe_reg #(.LANES(LANES), .PAYLOAD_W(PW), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_payload(in_payload),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_payload(out_payload), .out_ready(out_ready), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] lp(input logic [7:0] id, input logic [7:0] lane);
        logic [7:0] x;
        x = id ^ 8'hA5;
        return {id, 202'h0, x, lane};
    endfunction

    function automatic logic [BW-1:0] bund(input logic [7:0] id);
        return {lp(id, 8'd1), lp(id, 8'd0)};
    endfunction

    function automatic logic [BW-1:0] masked(input logic [LANES-1:0] v, input logic [BW-1:0] p);
        logic [BW-1:0] r;
        r = p;
        for (int i = 0; i < LANES; i++) if (!v[i]) r[i*PW +: PW] = '0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [LANES-1:0] v, input logic [7:0] id, input bit push);
        exp_t e;
        in_valid   = v;
        in_payload = bund(id);
        if (push) begin
            e.v = v;
            e.p = masked(v, bund(id));
            sb.push_back(e);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty, observed valid %b", tag, out_valid);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 512'(out_valid), 512'(e.v));
            chk({tag, "_payload"}, 512'(out_payload), 512'(e.p));
            $display("txn %s out_valid=%b lane0_hi=%0h stall=%0d", tag, out_valid,
                     out_payload[PW-1 -: 8], stall_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = '0; out_ready = 1'b0;
        drive(2'b11, 8'd1, 1'b0);
        step(); step();
        chk("rst_valid", 512'(out_valid), 512'(2'b00));
        chk("rst_payload", 512'(out_payload), 512'(0));
        chk("rst_stall", 512'(stall_cnt), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        rst_n = 1'b1;

        // Streaming
        out_ready = 1'b1;
        drive(2'b11, 8'd10, 1'b1); chk("strm_rdyA", 512'(in_ready), 512'(1));
        step();
        drive(2'b11, 8'd11, 1'b1); chk("strm_rdyB", 512'(in_ready), 512'(1));
        pop_cmp("strm_A");
        step();
        drive(2'b10, 8'd12, 1'b1); chk("strm_rdyC", 512'(in_ready), 512'(1));
        pop_cmp("strm_B");
        step();
        drive(2'b00, 8'd0, 1'b0);
        pop_cmp("strm_C");
        step();
        chk("strm_empty", 512'(out_valid), 512'(0));
        chk("strm_stall", 512'(stall_cnt), 512'(0));

        // Backpressure into skid
        drive(2'b01, 8'd20, 1'b1);
        step();
        out_ready = 1'b0;
        drive(2'b11, 8'd21, 1'b1); chk("bp_rdyB", 512'(in_ready), 512'(1));
        step();
        drive(2'b00, 8'd0, 1'b0);
        chk("bp_rdy0", 512'(in_ready), 512'(0));
        chk("bp_stall1", 512'(stall_cnt), 512'(1));
        step();
        chk("bp_rdy0b", 512'(in_ready), 512'(0));
        chk("bp_stall2", 512'(stall_cnt), 512'(2));
        out_ready = 1'b1;
        pop_cmp("bp_A");
        step();
        pop_cmp("bp_B");
        chk("bp_rdy1", 512'(in_ready), 512'(1));
        step();
        chk("bp_empty", 512'(out_valid), 512'(0));
        chk("bp_stall_hold", 512'(stall_cnt), 512'(2));

        // Younger-lane kill
        out_ready = 1'b0;
        drive(2'b11, 8'd30, 1'b0);
        step();
        drive(2'b00, 8'd0, 1'b0); flush = 2'b01;
        step();
        chk("kill01_valid", 512'(out_valid), 512'(0));
        chk("kill01_payload", 512'(out_payload), 512'(0));
        flush = 2'b00; drive(2'b11, 8'd31, 1'b0);
        step();
        drive(2'b00, 8'd0, 1'b0); flush = 2'b10;
        step();
        chk("kill10_valid", 512'(out_valid), 512'(2'b01));
        chk("kill10_payload", 512'(out_payload), 512'(masked(2'b01, bund(8'd31))));
        flush = 2'b00; out_ready = 1'b1;
        step();
        chk("kill_stall", 512'(stall_cnt), 512'(4));

        // Flush on the accepting edge
        drive(2'b11, 8'd40, 1'b0); flush = 2'b10;
        step();
        chk("fl_load_valid", 512'(out_valid), 512'(2'b01));
        chk("fl_load_payload", 512'(out_payload), 512'(masked(2'b01, bund(8'd40))));
        drive(2'b00, 8'd0, 1'b0); flush = 2'b00;
        step();

        // Flush empties main while skid survives: skid advances the same edge
        out_ready = 1'b0;
        drive(2'b10, 8'd50, 1'b0);
        step();
        drive(2'b11, 8'd51, 1'b0);
        step();
        drive(2'b00, 8'd0, 1'b0); flush = 2'b10;
        step();
        chk("fl_skid_valid", 512'(out_valid), 512'(2'b01));
        chk("fl_skid_payload", 512'(out_payload), 512'(masked(2'b01, bund(8'd51))));
        chk("fl_skid_rdy", 512'(in_ready), 512'(1));
        flush = 2'b00; out_ready = 1'b1;
        step();
        chk("fl_skid_empty", 512'(out_valid), 512'(0));
        chk("fl_skid_stall", 512'(stall_cnt), 512'(6));

        // Reset mid-transfer discards both entries
        out_ready = 1'b0;
        drive(2'b11, 8'd60, 1'b0);
        step();
        drive(2'b11, 8'd61, 1'b0);
        step();
        drive(2'b00, 8'd0, 1'b0); rst_n = 1'b0;
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk("mid_rst_valid", 512'(out_valid), 512'(0));
        chk("mid_rst_stall", 512'(stall_cnt), 512'(0));
        chk("mid_rst_rdy", 512'(in_ready), 512'(1));

        // Saturation
        out_ready = 1'b0;
        drive(2'b01, 8'd70, 1'b0);
        step();
        drive(2'b00, 8'd0, 1'b0);
        force dut.stall_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        step();
        chk("sat_1", 512'(stall_cnt), 512'(32'hFFFF_FFFF));
        step();
        chk("sat_2", 512'(stall_cnt), 512'(32'hFFFF_FFFF));
        step();
        chk("sat_3", 512'(stall_cnt), 512'(32'hFFFF_FFFF));
        chk("sat_valid", 512'(out_valid), 512'(2'b01));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
